// File: rtl/id_branch_resolver.sv
// IF/ID register + beq/bne/j resolve; redirects fetch and squashes FLUSH_SLOTS wrong-path captures.
// Latency: 1 cycle IF->ID capture, combinational redirect; in_stall holds IF/ID and defers any redirect.
// Optional ID_BRANCH_STATS_EN adds saturating branch/taken counters.
module id_branch_resolver #(
    parameter int DATA_W      = 32,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic [DATA_W-1:0] in_pc_plus_four,
    input  logic              in_stall,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic [DATA_W-1:0] out_instruction,
    output logic [DATA_W-1:0] out_pc_plus_four,
    output logic              out_valid,
    output logic              out_PCSrc,
    output logic [DATA_W-1:0] out_branch_address,
    output logic              out_flushing
`ifdef ID_BRANCH_STATS_EN
    ,
    output logic [15:0]       out_branch_count,
    output logic [15:0]       out_taken_count
`endif
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_SLOTS - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic [5:0]        opcode;
    logic              is_beq, is_bne, is_j, is_branch;
    logic              operands_eq, br_taken, redirect;
    logic [DATA_W-1:0] imm_offset, br_target, j_target;

    // Decode works on the registered instruction; rs/rt arrive from the regfile this cycle.
    always_comb begin
        opcode      = instr_q[31:26];
        is_beq      = (opcode == OP_BEQ);
        is_bne      = (opcode == OP_BNE);
        is_j        = (opcode == OP_J);
        is_branch   = is_beq | is_bne | is_j;
        operands_eq = (in_rs_data == in_rt_data);
        br_taken    = (is_beq & operands_eq) | (is_bne & ~operands_eq) | is_j;
        imm_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_target   = pc4_q + imm_offset;
        j_target    = {pc4_q[31:28], instr_q[25:0], 2'b00};
        redirect    = br_taken & valid_q & ~in_stall & (state_q == ST_RUN);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!in_stall) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = FLUSH_RELOAD;
                        state_d = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
                    end else begin
                        instr_d = in_instruction;
                        pc4_d   = in_pc_plus_four;
                        valid_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q - 2'd1;
                    state_d = (cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign out_instruction    = instr_q;
    assign out_pc_plus_four   = pc4_q;
    assign out_valid          = valid_q;
    assign out_PCSrc          = redirect;
    assign out_branch_address = redirect ? (is_j ? j_target : br_target) : '0;
    assign out_flushing       = (cnt_q != 2'd0);

`ifdef ID_BRANCH_STATS_EN
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (!in_stall && valid_q && is_branch && branch_cnt_q != 16'hFFFF)
            branch_cnt_d = branch_cnt_q + 16'd1;
        if (redirect && taken_cnt_q != 16'hFFFF)
            taken_cnt_d = taken_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= 16'd0;
            taken_cnt_q  <= 16'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign out_branch_count = branch_cnt_q;
    assign out_taken_count  = taken_cnt_q;
`else
    logic unused_is_branch;
    assign unused_is_branch = is_branch;
`endif

endmodule

// File: tb/tb_id_branch_resolver.sv
// Two resolvers (FLUSH_SLOTS=1 and 2) share one randomized input stream; each is scored
// against a per-instance reference model through an expectation queue.
module tb_id_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_instruction, in_pc_plus_four, in_rs_data, in_rt_data;
    logic        in_stall;

    logic [31:0] o_instr [2];
    logic [31:0] o_pc4   [2];
    logic [31:0] o_addr  [2];
    logic        o_valid [2];
    logic        o_pcsrc [2];
    logic        o_flush [2];
`ifdef ID_BRANCH_STATS_EN
    logic [15:0] o_bc [2];
    logic [15:0] o_tc [2];
`endif

    always #5 clk = ~clk;

    id_branch_resolver #(.DATA_W(32), .FLUSH_SLOTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_instruction(in_instruction), .in_pc_plus_four(in_pc_plus_four),
        .in_stall(in_stall), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .out_instruction(o_instr[0]), .out_pc_plus_four(o_pc4[0]), .out_valid(o_valid[0]),
        .out_PCSrc(o_pcsrc[0]), .out_branch_address(o_addr[0]), .out_flushing(o_flush[0])
`ifdef ID_BRANCH_STATS_EN
        , .out_branch_count(o_bc[0]), .out_taken_count(o_tc[0])
`endif
    );

    id_branch_resolver #(.DATA_W(32), .FLUSH_SLOTS(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_instruction(in_instruction), .in_pc_plus_four(in_pc_plus_four),
        .in_stall(in_stall), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .out_instruction(o_instr[1]), .out_pc_plus_four(o_pc4[1]), .out_valid(o_valid[1]),
        .out_PCSrc(o_pcsrc[1]), .out_branch_address(o_addr[1]), .out_flushing(o_flush[1])
`ifdef ID_BRANCH_STATS_EN
        , .out_branch_count(o_bc[1]), .out_taken_count(o_tc[1])
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic        valid;
        logic        pcsrc;
        logic        flushing;
        int          bc;
        int          tc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: IF/ID contents, remaining squash slots, statistics.
    int          fs      [2] = '{1, 2};
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4   [2];
    logic        m_valid [2];
    int          m_left  [2];
    int          m_bc    [2];
    int          m_tc    [2];

    function automatic void model_clear(int k);
        m_instr[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
        m_left[k] = 0; m_bc[k] = 0; m_tc[k] = 0;
    endfunction

    function automatic bit is_br(logic [31:0] ins);
        int op = int'(ins >> 26);
        return (op == 4) || (op == 5) || (op == 2);
    endfunction

    function automatic exp_t model_expect(int k);
        exp_t        e;
        int          op  = int'(m_instr[k] >> 26);
        logic [15:0] imm = m_instr[k][15:0];
        int          off = $signed(imm);
        bit          tk;
        logic [31:0] tgt;
        tk = (op == 4 && in_rs_data == in_rt_data) || (op == 5 && in_rs_data != in_rt_data) || op == 2;
        if (op == 2) tgt = (m_pc4[k] & 32'hF000_0000) | ((m_instr[k] & 32'h03FF_FFFF) << 2);
        else         tgt = m_pc4[k] + 32'(off * 4);
        e.instr    = m_instr[k];
        e.pc4      = m_pc4[k];
        e.valid    = m_valid[k];
        e.pcsrc    = tk && m_valid[k] && !in_stall && m_left[k] == 0;
        e.addr     = e.pcsrc ? tgt : 32'd0;
        e.flushing = (m_left[k] != 0);
        e.bc       = m_bc[k];
        e.tc       = m_tc[k];
        return e;
    endfunction

    // Apply one rising edge using the inputs that were held during the cycle just ended.
    function automatic void model_advance(int k);
        exp_t e;
        if (!rst_n) begin
            model_clear(k);
            return;
        end
        e = model_expect(k);
        if (in_stall) return;
        if (m_valid[k] && is_br(m_instr[k]) && m_bc[k] < 65535) m_bc[k]++;
        if (e.pcsrc && m_tc[k] < 65535) m_tc[k]++;
        if (e.pcsrc || m_left[k] > 0) begin
            m_left[k]  = e.pcsrc ? fs[k] - 1 : m_left[k] - 1;
            m_instr[k] = 0; m_pc4[k] = 0; m_valid[k] = 0;
        end else begin
            m_instr[k] = in_instruction; m_pc4[k] = in_pc_plus_four; m_valid[k] = 1;
        end
    endfunction

    task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_inst(int k, exp_t e);
        cmp("instruction", k, o_instr[k], e.instr);
        cmp("pc_plus_four", k, o_pc4[k], e.pc4);
        cmp("valid", k, 32'(o_valid[k]), 32'(e.valid));
        cmp("PCSrc", k, 32'(o_pcsrc[k]), 32'(e.pcsrc));
        cmp("branch_address", k, o_addr[k], e.addr);
        cmp("flushing", k, 32'(o_flush[k]), 32'(e.flushing));
`ifdef ID_BRANCH_STATS_EN
        cmp("branch_count", k, 32'(o_bc[k]), 32'(e.bc));
        cmp("taken_count", k, 32'(o_tc[k]), 32'(e.tc));
`endif
    endtask

    // Monitor: every cycle's outputs are scored mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); check_inst(0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); check_inst(1, e); end
        end
    end

    task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] p4,
                         input logic st, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_advance(k);
        #1;
        rst_n = r; in_instruction = ins; in_pc_plus_four = p4;
        in_stall = st; in_rs_data = rs; in_rt_data = rt;
        if (!r) for (int k = 0; k < 2; k++) model_clear(k);
        q0.push_back(model_expect(0));
        q1.push_back(model_expect(1));
        cyc++;
    endtask

    task automatic kchk(string name, int k, logic [31:0] act, logic [31:0] exp);
        cmp(name, k, act, exp);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0020;

    initial begin
        logic [31:0] r32, ins, rs;
        int          sel;
        rst_n = 1'b0; in_instruction = 0; in_pc_plus_four = 0;
        in_stall = 0; in_rs_data = 0; in_rt_data = 0;
        for (int k = 0; k < 2; k++) model_clear(k);

        // Reset mid-stream, then release with a taken beq arriving.
        cycle(1, 32'h1000_0003, 32'd4, 0, 1, 1);
        cycle(1, 32'h1000_0003, 32'd4, 0, 1, 1);
        cycle(0, 32'hDEAD_BEEF, 32'd44, 0, 3, 3);
        @(negedge clk);
        kchk("reset_valid", 0, 32'(o_valid[0]), 0);
        kchk("reset_instr", 1, o_instr[1], 0);
        cycle(1, 32'h1000_0003, 32'd8, 0, 0, 1);
        @(negedge clk);
        kchk("release_valid", 0, 32'(o_valid[0]), 0);
        cycle(1, NOP, 32'd12, 0, 5, 5);
        @(negedge clk);
        kchk("first_capture", 0, o_instr[0], 32'h1000_0003);
        kchk("beq_pcsrc", 0, 32'(o_pcsrc[0]), 1);
        kchk("beq_addr", 0, o_addr[0], 32'd20);
        cycle(1, 32'h1400_0002, 32'd24, 0, 7, 7);
        @(negedge clk);
        kchk("bubble_instr", 0, o_instr[0], 0);
        kchk("bubble_flush1", 0, 32'(o_flush[0]), 0);
        kchk("bubble_flush2", 1, 32'(o_flush[1]), 1);
        cycle(1, 32'h0800_0040, 32'h1000_0004, 0, 7, 7);
        @(negedge clk);
        kchk("bne_pcsrc", 0, 32'(o_pcsrc[0]), 0);
        kchk("bne_addr", 0, o_addr[0], 0);
        kchk("slot2_valid", 1, 32'(o_valid[1]), 0);
        cycle(1, 32'h1000_FFFF, 32'd0, 0, 7, 7);
        @(negedge clk);
        kchk("j_addr", 0, o_addr[0], 32'h1000_0100);
        cycle(1, 32'h1000_FFFF, 32'd0, 0, 3, 3);
        cycle(1, 32'h1000_FFFF, 32'd0, 0, 3, 3);
        @(negedge clk);
        kchk("beq_neg_addr", 0, o_addr[0], 32'hFFFF_FFFC);

        // Stall holds a taken branch; it redirects when the stall drops.
        for (int i = 0; i < 4; i++) cycle(1, NOP, 32'h80, 0, 1, 2);
        cycle(1, 32'h1000_0003, 32'h100, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            cycle(1, NOP, 32'h104, 1, 9, 9);
            @(negedge clk);
            kchk("stall_pcsrc", 0, 32'(o_pcsrc[0]), 0);
            kchk("stall_hold", 1, o_instr[1], 32'h1000_0003);
        end
        cycle(1, NOP, 32'h104, 0, 9, 9);
        @(negedge clk);
        kchk("unstall_pcsrc", 1, 32'(o_pcsrc[1]), 1);
        kchk("unstall_addr", 0, o_addr[0], 32'h10C);

        // Randomized traffic with occasional reset and stall.
        for (int i = 0; i < 3000; i++) begin
            r32 = $urandom();
            sel = $urandom_range(0, 9);
            if (sel < 3)      ins = {6'h04, r32[25:0]};
            else if (sel < 6) ins = {6'h05, r32[25:0]};
            else if (sel < 8) ins = {6'h02, r32[25:0]};
            else              ins = {(sel == 8) ? 6'h00 : 6'h23, r32[25:0]};
            rs = $urandom_range(0, 3);
            cycle(($urandom_range(0, 149) != 0), ins, $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) == 0), rs,
                  ($urandom_range(0, 1) == 0) ? rs : 32'($urandom_range(0, 3)));
        end

        @(negedge clk);
        @(negedge clk);
        cmp("queue0_drained", 0, q0.size(), 0);
        cmp("queue1_drained", 1, q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
